shift_reg_univ: RTL and testbench

SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

---
 rtl/shift_reg_univ.sv | 99 +++++++++
 tb/tb_shift_reg_univ.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold, shift left/right, parallel load and clear,
// with a saturating shift counter. Define SHIFT_REG_ROTATE_EN to enable rotate modes 100/101.
module shift_reg_univ #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_SHL   = 3'b001,
    M_SHR   = 3'b010,
    M_LOAD  = 3'b011,
    M_ROL   = 3'b100,
    M_ROR   = 3'b101,
    M_CLR   = 3'b110,
    M_HOLD2 = 3'b111
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [WIDTH-1:0] q_nxt;
  logic             sout_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;

  // Saturating increment shared by every shift and rotate.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    q_nxt    = q;
    sout_nxt = sout;
    cnt_nxt  = cnt;
    case (mode_e'(mode))
      M_SHL: begin
        q_nxt    = {q[WIDTH-2:0], sin_l};
        sout_nxt = q[WIDTH-1];
        cnt_nxt  = cnt_inc;
      end
      M_SHR: begin
        q_nxt    = {sin_r, q[WIDTH-1:1]};
        sout_nxt = q[0];
        cnt_nxt  = cnt_inc;
      end
      M_LOAD: begin
        q_nxt    = d;
        sout_nxt = 1'b0;
        cnt_nxt  = '0;
      end
`ifdef SHIFT_REG_ROTATE_EN
      M_ROL: begin
        q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
        sout_nxt = q[WIDTH-1];
        cnt_nxt  = cnt_inc;
      end
      M_ROR: begin
        q_nxt    = {q[0], q[WIDTH-1:1]};
        sout_nxt = q[0];
        cnt_nxt  = cnt_inc;
      end
`endif
      M_CLR: begin
        q_nxt    = '0;
        sout_nxt = 1'b0;
        cnt_nxt  = '0;
      end
      default: ;  // hold, including 111 and rotate codes when rotate is off
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      q    <= '0;
      sout <= 1'b0;
      cnt  <= '0;
    end else if (en) begin
      q    <= q_nxt;
      sout <= sout_nxt;
      cnt  <= cnt_nxt;
    end
  end

  assign done = (cnt == CNT_MAX);

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ: directed scenarios plus random
// stimulus checked against an arithmetic reference model.
module tb_shift_reg_univ;
  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam longint unsigned FULL = 64'd1 << WIDTH;
  localparam longint unsigned HALF = 64'd1 << (WIDTH - 1);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             en = 1'b0;
  logic [2:0]       mode = 3'b000;
  logic [WIDTH-1:0] d = '0;
  logic             sin_l = 1'b0;
  logic             sin_r = 1'b0;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic [CNT_W-1:0] cnt;
  logic             done;

  int total = 0;
  int bad   = 0;

  longint unsigned m_q = 0;
  int              m_sout = 0;
  int              m_cnt = 0;

  shift_reg_univ #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d),
    .sin_l(sin_l), .sin_r(sin_r), .q(q), .sout(sout), .cnt(cnt), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void bump();
    if (m_cnt < WIDTH) m_cnt++;
  endfunction

  // Reference: register held as an integer, shifts as multiply/divide.
  function automatic void model_edge(input bit rst, input bit e, input bit [2:0] md,
                                     input bit [WIDTH-1:0] dd, input bit sl, input bit sr);
    if (!rst) begin
      m_q = 0; m_sout = 0; m_cnt = 0;
    end else if (e) begin
      case (md)
        3'd1: begin m_sout = int'(m_q / HALF); m_q = (m_q * 2 + sl) % FULL; bump(); end
        3'd2: begin m_sout = int'(m_q % 2); m_q = m_q / 2 + sr * HALF; bump(); end
        3'd3: begin m_q = dd; m_sout = 0; m_cnt = 0; end
`ifdef SHIFT_REG_ROTATE_EN
        3'd4: begin m_sout = int'(m_q / HALF); m_q = (m_q * 2 + m_q / HALF) % FULL; bump(); end
        3'd5: begin m_sout = int'(m_q % 2); m_q = m_q / 2 + (m_q % 2) * HALF; bump(); end
`endif
        3'd6: begin m_q = 0; m_sout = 0; m_cnt = 0; end
        default: ;
      endcase
    end
  endfunction

  task automatic cyc(input bit rst, input bit e, input bit [2:0] md, input bit [WIDTH-1:0] dd,
                     input bit sl, input bit sr, input string tag);
    reset = rst; en = e; mode = md; d = dd; sin_l = sl; sin_r = sr;
    @(posedge clk);
    model_edge(rst, e, md, dd, sl, sr);
    #1;
    check({tag, "_q"}, 64'(q), 64'(m_q));
    check({tag, "_sout"}, 64'(sout), 64'(m_sout));
    check({tag, "_cnt"}, 64'(cnt), 64'(m_cnt));
    check({tag, "_done"}, 64'(done), 64'(m_cnt == WIDTH));
  endtask

  initial begin
    bit [7:0] sout_seq;
    sout_seq = 8'b1010_0101;

    // Reset wins over a load.
    cyc(0, 1, 3'b011, 8'hA5, 0, 0, "rst_load");
    check("r22_q", 64'(q), 64'h00);
    check("r22_done", 64'(done), 64'h0);

    // Shift A5 out to the left, watching sout, then saturate.
    cyc(1, 1, 3'b011, 8'hA5, 0, 0, "load_a5");
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, 3'b001, '0, 0, 0, "shl_a5");
      check("r23_sout", 64'(sout), 64'(sout_seq[7-i]));
    end
    check("r23_q", 64'(q), 64'h00);
    check("r23_cnt", 64'(cnt), 64'd8);
    check("r23_done", 64'(done), 64'h1);
    cyc(1, 1, 3'b001, '0, 0, 0, "shl_sat");
    check("r23_sat", 64'(cnt), 64'd8);

    // Shift right with sin_r=1.
    cyc(1, 1, 3'b011, 8'h81, 0, 0, "load_81");
    cyc(1, 1, 3'b010, '0, 0, 1, "shr");
    check("r24_q", 64'(q), 64'hC0);
    check("r24_sout", 64'(sout), 64'h1);

    // Enable low holds everything.
    cyc(1, 1, 3'b011, 8'h3C, 0, 0, "load_3c");
    for (int i = 0; i < 4; i++) cyc(1, 0, 3'b001, 8'hFF, 1, 1, "en_off");
    check("r25_q", 64'(q), 64'h3C);

    // Rotate left, or hold when rotate is disabled.
    cyc(1, 1, 3'b011, 8'h81, 0, 0, "load_81b");
    cyc(1, 1, 3'b100, '0, 0, 0, "rol");
`ifdef SHIFT_REG_ROTATE_EN
    check("r26_q", 64'(q), 64'h03);
`else
    check("r26_q", 64'(q), 64'h81);
`endif
    cyc(1, 1, 3'b101, '0, 0, 0, "ror");
    cyc(1, 1, 3'b111, 8'h55, 1, 1, "m111");
    cyc(1, 1, 3'b110, '0, 0, 0, "clr");

    // Mid-sequence reset discards the partial count.
    cyc(1, 1, 3'b011, 8'hFF, 0, 0, "load_ff");
    for (int i = 0; i < 3; i++) cyc(1, 1, 3'b001, '0, 0, 0, "shl_ff");
    cyc(0, 1, 3'b001, '0, 1, 0, "mid_rst");
    check("r27_cnt", 64'(cnt), 64'd0);
    cyc(1, 1, 3'b001, '0, 1, 0, "post_rst");
    check("r27_q", 64'(q), 64'h01);
    check("r27_cnt", 64'(cnt), 64'd1);

    // A reset glitch between edges is ignored.
    cyc(1, 1, 3'b011, 8'h5A, 0, 0, "load_5a");
    #1 reset = 1'b0;
    #1 reset = 1'b1;
    cyc(1, 1, 3'b000, '0, 0, 0, "glitch");
    check("r19_q", 64'(q), 64'h5A);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 19) != 0), ($urandom_range(0, 4) != 0),
          3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), 1'($urandom), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
